// File: rtl/reg_4b_checker.sv
// Built-in self-test sequencer for an external 4-bit enable register: writes a
// walking value, then checks it both right after the write and one idle cycle later.
module reg_4b_checker #(
  parameter logic [3:0] STEP      = 4'd1,
  parameter logic [3:0] START_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       reg_en,
  output logic [3:0] reg_d,
  input  logic [3:0] reg_q,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [3:0] fail_val,
  output logic [3:0] fail_q,
  output logic       fail_phase
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_HOLD,
    S_CHK,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_v;
  logic [3:0]  r_iter;
  logic [5:0]  r_err;
  logic [3:0]  r_fail_val;
  logic [3:0]  r_fail_q;
  logic        r_fail_phase;

  logic        w_load;
  logic        w_adv;
  logic        w_cmp_en;
  logic        w_phase;
  logic        w_mismatch;

  always_comb begin
    w_next   = r_state;
    reg_en   = 1'b0;
    reg_d    = '0;
    w_load   = 1'b0;
    w_adv    = 1'b0;
    w_cmp_en = 1'b0;
    w_phase  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_WR;
        end
      end
      S_WR: begin
        reg_en = 1'b1;
        reg_d  = r_v;
        w_next = S_HOLD;
      end
      // Driving ~v while disabled makes a register that ignores en visibly corrupt.
      S_HOLD: begin
        reg_d    = ~r_v;
        w_cmp_en = 1'b1;
        w_phase  = 1'b0;
        w_next   = S_CHK;
      end
      S_CHK: begin
        reg_d    = ~r_v;
        w_cmp_en = 1'b1;
        w_phase  = 1'b1;
        w_adv    = 1'b1;
        w_next   = (r_iter == 4'd15) ? S_DONE : S_WR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_mismatch = w_cmp_en && (reg_q != r_v);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_v          <= '0;
      r_iter       <= '0;
      r_err        <= '0;
      r_fail_val   <= '0;
      r_fail_q     <= '0;
      r_fail_phase <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_v          <= START_VAL;
        r_iter       <= '0;
        r_err        <= '0;
        r_fail_val   <= '0;
        r_fail_q     <= '0;
        r_fail_phase <= 1'b0;
      end else begin
        if (w_mismatch) begin
          r_err <= r_err + 6'd1;
          // Only the first mismatch of a run is recorded.
          if (r_err == '0) begin
            r_fail_val   <= r_v;
            r_fail_q     <= reg_q;
            r_fail_phase <= w_phase;
          end
        end
        if (w_adv) begin
          r_v    <= r_v + STEP;
          r_iter <= r_iter + 4'd1;
        end
      end
    end
  end

  assign busy       = (r_state == S_WR) || (r_state == S_HOLD) || (r_state == S_CHK);
  assign done       = (r_state == S_DONE);
  assign pass       = done && (r_err == '0);
  assign err_count  = r_err;
  assign fail_val   = r_fail_val;
  assign fail_q     = r_fail_q;
  assign fail_phase = r_fail_phase;

endmodule

// File: tb/tb_reg_4b_checker.sv
// Directed bench for reg_4b_checker: behavioural registers (good, stuck bit, ignores en)
// and a second instance with non-default STEP/START_VAL.
module tb_reg_4b_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] q1 = '0;
  logic [3:0] q2 = '0;

  logic       en1, busy1, done1, pass1, fp1;
  logic [3:0] d1, fv1, fq1;
  logic [5:0] err1;
  logic       en2, busy2, done2, pass2, fp2;
  logic [3:0] d2, fv2, fq2;
  logic [5:0] err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_4b_checker u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .reg_en(en1), .reg_d(d1), .reg_q(q1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_val(fv1), .fail_q(fq1), .fail_phase(fp1)
  );

  reg_4b_checker #(.STEP(4'd5), .START_VAL(4'd3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .reg_en(en2), .reg_d(d2), .reg_q(q2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_val(fv2), .fail_q(fq2), .fail_phase(fp2)
  );

  // mode 0: correct register, 1: bit 2 stuck at 0, 2: loads every cycle
  always @(posedge clk) begin
    case (mode)
      2'd0:    if (en1) q1 <= d1;
      2'd1:    if (en1) q1 <= d1 & 4'b1011;
      default: q1 <= d1;
    endcase
    if (en2) q2 <= d2;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks cycles k_first..k_last of a run, one per falling edge.
  task automatic watch(input int which, input logic [3:0] sv, input logic [3:0] st,
                       input int k_first, input int k_last, input bit hold);
    logic       b, dn, e;
    logic [3:0] rd, v, exp_d;
    for (int k = k_first; k <= k_last; k++) begin
      @(negedge clk);
      if (!hold) begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
      if (which == 1) begin
        b = busy1; dn = done1; e = en1; rd = d1;
      end else begin
        b = busy2; dn = done2; e = en2; rd = d2;
      end
      v = sv + st * 4'(k / 3);
      exp_d = (k % 3 == 0) ? v : ~v;
      check($sformatf("dut%0d busy k%0d", which, k), 32'(b), 32'd1);
      check($sformatf("dut%0d done k%0d", which, k), 32'(dn), 32'd0);
      check($sformatf("dut%0d reg_en k%0d", which, k), 32'(e), 32'(k % 3 == 0));
      check($sformatf("dut%0d reg_d k%0d", which, k), 32'(rd), 32'(exp_d));
    end
  endtask

  task automatic check_done(input int which, input logic [5:0] err, input logic [3:0] fv,
                            input logic [3:0] fq, input logic fp, input logic ps);
    @(negedge clk);
    if (which == 1) begin
      check("dut1 done", 32'(done1), 32'd1);
      check("dut1 busy_off", 32'(busy1), 32'd0);
      check("dut1 reg_en_off", 32'(en1), 32'd0);
      check("dut1 reg_d_zero", 32'(d1), 32'd0);
      check("dut1 err_count", 32'(err1), 32'(err));
      check("dut1 fail_val", 32'(fv1), 32'(fv));
      check("dut1 fail_q", 32'(fq1), 32'(fq));
      check("dut1 fail_phase", 32'(fp1), 32'(fp));
      check("dut1 pass", 32'(pass1), 32'(ps));
    end else begin
      check("dut2 done", 32'(done2), 32'd1);
      check("dut2 busy_off", 32'(busy2), 32'd0);
      check("dut2 err_count", 32'(err2), 32'(err));
      check("dut2 pass", 32'(pass2), 32'(ps));
    end
  endtask

  initial begin
    // reset held low for two cycles
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst pass", 32'(pass1), 32'd0);
    check("rst reg_en", 32'(en1), 32'd0);
    check("rst reg_d", 32'(d1), 32'd0);
    check("rst err", 32'(err1), 32'd0);
    check("rst fail", 32'({fv1, fq1, fp1}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(busy1), 32'd0);

    // clean run, default parameters
    mode = 2'd0;
    start1 = 1'b1;
    watch(1, 4'd0, 4'd1, 0, 47, 1'b0);
    check_done(1, 6'd0, 4'd0, 4'd0, 1'b0, 1'b1);

    // bit 2 stuck at 0
    mode = 2'd1;
    start1 = 1'b1;
    watch(1, 4'd0, 4'd1, 0, 47, 1'b0);
    check_done(1, 6'd16, 4'd4, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("done hold err", 32'(err1), 32'd16);
    check("done hold state", 32'(done1), 32'd1);

    // register ignoring enable
    mode = 2'd2;
    start1 = 1'b1;
    watch(1, 4'd0, 4'd1, 0, 0, 1'b0);
    check("restart err clr", 32'(err1), 32'd0);
    check("restart fail_val clr", 32'(fv1), 32'd0);
    watch(1, 4'd0, 4'd1, 1, 47, 1'b0);
    check_done(1, 6'd16, 4'd0, 4'hF, 1'b1, 1'b0);

    // STEP=5, START_VAL=3, extra start at cycle 20 ignored
    start2 = 1'b1;
    watch(2, 4'd3, 4'd5, 0, 19, 1'b0);
    start2 = 1'b1;
    watch(2, 4'd3, 4'd5, 20, 47, 1'b0);
    check_done(2, 6'd0, 4'd0, 4'd0, 1'b0, 1'b1);

    // asynchronous reset at cycle 10 of a run
    start1 = 1'b1;
    watch(1, 4'd0, 4'd1, 0, 9, 1'b0);
    check("pre-reset err", 32'(err1), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("async busy", 32'(busy1), 32'd0);
    check("async done", 32'(done1), 32'd0);
    check("async reg_en", 32'(en1), 32'd0);
    check("async reg_d", 32'(d1), 32'd0);
    check("async err", 32'(err1), 32'd0);
    check("async fail", 32'({fv1, fq1, fp1}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mode = 2'd0;
    repeat (2) @(negedge clk);
    check("post-reset idle busy", 32'(busy1), 32'd0);
    check("post-reset idle done", 32'(done1), 32'd0);
    start1 = 1'b1;
    watch(1, 4'd0, 4'd1, 0, 47, 1'b0);
    check_done(1, 6'd0, 4'd0, 4'd0, 1'b0, 1'b1);

    // start held high: back-to-back runs with one DONE cycle
    mode = 2'd1;
    start1 = 1'b1;
    watch(1, 4'd0, 4'd1, 0, 47, 1'b1);
    check_done(1, 6'd16, 4'd4, 4'd0, 1'b0, 1'b0);
    watch(1, 4'd0, 4'd1, 0, 0, 1'b1);
    check("b2b err clr", 32'(err1), 32'd0);
    check("b2b fail_val clr", 32'(fv1), 32'd0);
    watch(1, 4'd0, 4'd1, 1, 47, 1'b1);
    check_done(1, 6'd16, 4'd4, 4'd0, 1'b0, 1'b0);
    start1 = 1'b0;
    @(negedge clk);
    check("b2b stay done", 32'(done1), 32'd1);
    check("b2b stay idle", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
